// File: rtl/traffic_source.sv
// traffic_source: packet injector for router benches.
// Emits PACKETS packets (0 = unlimited) of FLITS flits over a req/ack channel.
// The head flit carries the destination: fixed, LFSR-random or round-robin.
// Body flits carry {ID, flit index}. A programmable gap separates packets.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   en         permission to start a new packet (sampled only while idle)
//   ch_req     flit valid (registered)
//   ch_ack     sink accept; a flit moves on an edge with ch_req & ch_ack
//   ch_data    flit payload, zero while ch_req is low (registered)
//   done       sticky, set once PACKETS packets have transferred (registered)
//   pkt_count  completed packets, wraps modulo 2^CNT_BITS (registered)
//
// Optional feature: define TRAFFIC_SOURCE_RAND_GAP_EN to draw each
// inter-packet gap from the LFSR (lfsr[7:0] mod (GAP+1)) instead of using a
// fixed GAP.
module traffic_source #(
  parameter int unsigned ID       = 0,
  parameter int unsigned SIZE     = 8,
  parameter int unsigned FLITS    = 8,
  parameter int unsigned PACKETS  = 1,
  parameter int unsigned MODE     = 1,
  parameter int unsigned DEST     = 0,
  parameter int unsigned GAP      = 0,
  parameter int unsigned SEED     = 5,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic                ch_req,
  input  logic                ch_ack,
  output logic [SIZE-1:0]     ch_data,
  output logic                done,
  output logic [CNT_BITS-1:0] pkt_count
);

  localparam int unsigned DEST_BITS = SIZE - 1;
  localparam int unsigned FIDX_BITS = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam int unsigned GAP_BITS  = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int unsigned BODY_BITS = 32 + FIDX_BITS;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LFSR_INIT = (SEED == 0) ? 16'd1 : 16'(SEED);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_BODY,
    S_GAP,
    S_DONE
  } state_t;

  state_t                state, state_n;
  logic [FIDX_BITS-1:0]  flit_idx, flit_idx_n;
  logic [DEST_BITS-1:0]  rr, rr_n;
  logic [DEST_BITS-1:0]  dest_sel;
  logic [15:0]           lfsr, lfsr_n;
  logic [GAP_BITS-1:0]   gap_cnt, gap_n;
  logic [CNT_BITS-1:0]   cnt_n;
  logic                  req_n;
  logic [SIZE-1:0]       data_n;
  logic                  done_n;

  // 16-bit Galois LFSR, right shift
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Body flit: {ID, idx} LSB-aligned, fitted to the low SIZE-1 bits
  function automatic logic [SIZE-1:0] body_flit(input logic [FIDX_BITS-1:0] idx);
    logic [BODY_BITS-1:0] raw;
    raw       = {32'(ID), idx};
    body_flit = {1'b0, DEST_BITS'(raw)};
  endfunction

  // Destination for the next head, taken from pre-advance LFSR in random mode
  always_comb begin
    case (MODE)
      1:       dest_sel = DEST_BITS'(lfsr);
      2:       dest_sel = rr;
      default: dest_sel = DEST_BITS'(DEST);
    endcase
  end

`ifdef TRAFFIC_SOURCE_RAND_GAP_EN
  logic [GAP_BITS-1:0] gap_load;
  assign gap_load = GAP_BITS'(32'(lfsr[7:0]) % (GAP + 1));
`endif

  // Next-state and registered-output values
  always_comb begin
    state_n    = state;
    flit_idx_n = flit_idx;
    rr_n       = rr;
    lfsr_n     = lfsr;
    gap_n      = gap_cnt;
    cnt_n      = pkt_count;
    req_n      = ch_req;
    data_n     = ch_data;

    case (state)
      S_IDLE: begin
        if (en) begin
          state_n    = S_HEAD;
          flit_idx_n = '0;
          lfsr_n     = lfsr_next(lfsr);
          req_n      = 1'b1;
          data_n     = {1'b1, dest_sel};
        end
      end
      S_HEAD: begin
        if (ch_ack) begin
          rr_n = rr + DEST_BITS'(1);
          if (FLITS > 1) begin
            state_n    = S_BODY;
            flit_idx_n = FIDX_BITS'(1);
            data_n     = body_flit(FIDX_BITS'(1));
          end
        end
      end
      S_BODY: begin
        if (ch_ack && flit_idx != FIDX_BITS'(FLITS - 1)) begin
          flit_idx_n = flit_idx + FIDX_BITS'(1);
          data_n     = body_flit(flit_idx + FIDX_BITS'(1));
        end
      end
      S_GAP: begin
        if (gap_cnt <= GAP_BITS'(1)) state_n = S_IDLE;
        else                         gap_n   = gap_cnt - GAP_BITS'(1);
      end
      S_DONE: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase

    // Packet completion: last flit accepted this edge
    if (ch_ack && ((state == S_HEAD && FLITS == 1) ||
                   (state == S_BODY && flit_idx == FIDX_BITS'(FLITS - 1)))) begin
      cnt_n      = pkt_count + CNT_BITS'(1);
      flit_idx_n = '0;
      req_n      = 1'b0;
      data_n     = '0;
      if (PACKETS != 0 && cnt_n == CNT_BITS'(PACKETS)) begin
        state_n = S_DONE;
`ifdef TRAFFIC_SOURCE_RAND_GAP_EN
      end else if (GAP > 0) begin
        lfsr_n = lfsr_next(lfsr);
        if (gap_load != '0) begin
          state_n = S_GAP;
          gap_n   = gap_load;
        end else begin
          state_n = S_IDLE;
        end
`else
      end else if (GAP > 0) begin
        state_n = S_GAP;
        gap_n   = GAP_BITS'(GAP);
`endif
      end else begin
        state_n = S_IDLE;
      end
    end

    done_n = (state_n == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      flit_idx  <= '0;
      rr        <= DEST_BITS'(DEST);
      lfsr      <= LFSR_INIT;
      gap_cnt   <= '0;
      pkt_count <= '0;
      ch_req    <= 1'b0;
      ch_data   <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      flit_idx  <= flit_idx_n;
      rr        <= rr_n;
      lfsr      <= lfsr_n;
      gap_cnt   <= gap_n;
      pkt_count <= cnt_n;
      ch_req    <= req_n;
      ch_data   <= data_n;
      done      <= done_n;
    end
  end

endmodule
